// File: rtl/roi_capture_ctrl.sv
// roi_capture_ctrl
//   Captures one binary frame from a pixel stream into a linear buffer.
//   Frame boundaries are found by counting consecutive iDVAL-low cycles;
//   a capture only starts on the first valid pixel that follows a full gap.
//
// Parameters
//   H_ACTIVE    pixels per row
//   V_ACTIVE    rows per frame
//   GAP_THRESH  consecutive iDVAL-low cycles that mark a frame boundary
//
// Ports
//   iCLK          pixel clock, rising edge
//   iRST          asynchronous, active-low reset
//   iDVAL         pixel-valid strobe
//   iDATA         binary pixel value
//   iStart        capture request (sampled in IDLE only)
//   iRead_done    consumer finished reading the buffer (honoured in READY only)
//   oWr_en        buffer write strobe
//   oWr_addr      linear write address, row*H_ACTIVE+col
//   oWr_data      pixel to write
//   oFrame_ready  a complete frame is held in the buffer
//   oBusy         high in ARMED or CAPTURE
//   oShort_frame  one-cycle pulse: capture aborted on a premature gap
//   oState        IDLE=0, ARMED=1, CAPTURE=2, READY=3
//   oFrame_count  completed captures, wraps 255->0
module roi_capture_ctrl #(
  parameter int H_ACTIVE   = 320,
  parameter int V_ACTIVE   = 240,
  parameter int GAP_THRESH = 400
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iDVAL,
  input  logic        iDATA,
  input  logic        iStart,
  input  logic        iRead_done,
  output logic        oWr_en,
  output logic [16:0] oWr_addr,
  output logic        oWr_data,
  output logic        oFrame_ready,
  output logic        oBusy,
  output logic        oShort_frame,
  output logic [1:0]  oState,
  output logic [7:0]  oFrame_count
);

  localparam int              GAP_W    = $clog2(GAP_THRESH + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_THRESH);
  localparam logic [8:0]      COL_LAST = 9'(H_ACTIVE - 1);
  localparam logic [7:0]      ROW_LAST = 8'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gapCnt;
  logic             gapFlag;
  logic [8:0]       col;
  logic [7:0]       row;
  logic [16:0]      addrCnt;
  logic             lastPix;

  logic             wrEn_p1;
  logic [16:0]      wrAddr_p1;
  logic             wrData_p1;
  logic             shortFrame_p1;
  logic [7:0]       frameCount;

  // Gap detector runs in every state so ARMED already knows whether the
  // stream is sitting in a frame gap when capture is requested.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      gapCnt <= '0;
    end else if (iDVAL) begin
      gapCnt <= '0;
    end else if (gapCnt != GAP_MAX) begin
      gapCnt <= gapCnt + GAP_W'(1);
    end
  end

  assign gapFlag = (gapCnt == GAP_MAX);

  // row/col locate the pixel about to be written; addrCnt tracks the same
  // position as a linear address so no multiplier is needed.
  assign lastPix = (row == ROW_LAST) && (col == COL_LAST);

  // Stage p0 -> p1: accepted pixel is registered onto the write port.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state         <= IDLE;
      wrEn_p1       <= 1'b0;
      wrAddr_p1     <= '0;
      wrData_p1     <= 1'b0;
      shortFrame_p1 <= 1'b0;
      frameCount    <= '0;
      col           <= '0;
      row           <= '0;
      addrCnt       <= '0;
    end else begin
      wrEn_p1       <= 1'b0;
      shortFrame_p1 <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) state <= ARMED;
        end

        ARMED: begin
          // Only a pixel that follows a full gap is a frame start.
          if (iDVAL && gapFlag) begin
            state     <= CAPTURE;
            wrEn_p1   <= 1'b1;
            wrAddr_p1 <= '0;
            wrData_p1 <= iDATA;
            addrCnt   <= 17'd1;
            if (COL_LAST == 9'd0) begin
              col <= '0;
              row <= 8'd1;
            end else begin
              col <= 9'd1;
              row <= '0;
            end
          end
        end

        CAPTURE: begin
          // The final pixel wins over a coincident gap flag.
          if (iDVAL && lastPix) begin
            state      <= READY;
            wrEn_p1    <= 1'b1;
            wrAddr_p1  <= addrCnt;
            wrData_p1  <= iDATA;
            frameCount <= frameCount + 8'd1;
            col        <= '0;
            row        <= '0;
            addrCnt    <= '0;
          end else if (gapFlag) begin
            state         <= ARMED;
            shortFrame_p1 <= 1'b1;
            col           <= '0;
            row           <= '0;
            addrCnt       <= '0;
          end else if (iDVAL) begin
            wrEn_p1   <= 1'b1;
            wrAddr_p1 <= addrCnt;
            wrData_p1 <= iDATA;
            addrCnt   <= addrCnt + 17'd1;
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 8'd1;
            end else begin
              col <= col + 9'd1;
            end
          end
        end

        READY: begin
          if (iRead_done) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign oWr_en       = wrEn_p1;
  assign oWr_addr     = wrAddr_p1;
  assign oWr_data     = wrData_p1;
  assign oShort_frame = shortFrame_p1;
  assign oFrame_count = frameCount;
  assign oState       = state;
  assign oFrame_ready = (state == READY);
  assign oBusy        = (state == ARMED) || (state == CAPTURE);

endmodule

// File: tb/tb_roi_capture_ctrl.sv
module tb_roi_capture_ctrl;

  localparam int H = 8;
  localparam int V = 4;
  localparam int G = 16;
  localparam int N = H * V;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iDVAL;
  logic        iDATA;
  logic        iStart;
  logic        iRead_done;
  logic        oWr_en;
  logic [16:0] oWr_addr;
  logic        oWr_data;
  logic        oFrame_ready;
  logic        oBusy;
  logic        oShort_frame;
  logic [1:0]  oState;
  logic [7:0]  oFrame_count;

  int vectors = 0;
  int fails   = 0;
  int wrCount = 0;
  logic [17:0] expQ[$];

  roi_capture_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .GAP_THRESH(G)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDVAL(iDVAL), .iDATA(iDATA),
    .iStart(iStart), .iRead_done(iRead_done),
    .oWr_en(oWr_en), .oWr_addr(oWr_addr), .oWr_data(oWr_data),
    .oFrame_ready(oFrame_ready), .oBusy(oBusy), .oShort_frame(oShort_frame),
    .oState(oState), .oFrame_count(oFrame_count)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write the DUT produces must match the oldest expected one.
  always @(negedge iCLK) begin
    if (iRST === 1'b1 && oWr_en === 1'b1) begin
      wrCount++;
      chk("write_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        logic [17:0] e;
        e = expQ.pop_front();
        chk("wr_addr", 32'(oWr_addr), 32'(e[17:1]));
        chk("wr_data", 32'(oWr_data), 32'(e[0]));
      end
    end
  end

  task automatic idle(input int n);
    iDVAL = 1'b0;
    iDATA = 1'b0;
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic px(input logic d, input bit expWr, input int addr);
    logic [16:0] a;
    a = 17'(addr);
    iDVAL = 1'b1;
    iDATA = d;
    if (expWr) expQ.push_back({a, d});
    @(posedge iCLK);
    #1;
    iDVAL = 1'b0;
    iDATA = 1'b0;
  endtask

  task automatic pulseStart();
    iStart = 1'b1;
    @(posedge iCLK);
    #1;
    iStart = 1'b0;
  endtask

  task automatic pulseDone();
    iRead_done = 1'b1;
    @(posedge iCLK);
    #1;
    iRead_done = 1'b0;
  endtask

  function automatic logic pat(input int i);
    return logic'(((i * 5) ^ (i >> 2)) & 1);
  endfunction

  initial begin
    int wrBase;
    iRST = 1'b0; iDVAL = 1'b0; iDATA = 1'b0; iStart = 1'b0; iRead_done = 1'b0;

    // Reset state
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_state", 32'(oState), 32'd0);
    chk("rst_wr_en", 32'(oWr_en), 32'd0);
    chk("rst_wr_addr", 32'(oWr_addr), 32'd0);
    chk("rst_wr_data", 32'(oWr_data), 32'd0);
    chk("rst_frame_ready", 32'(oFrame_ready), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_short", 32'(oShort_frame), 32'd0);
    chk("rst_count", 32'(oFrame_count), 32'd0);
    iRST = 1'b1;
    idle(2);

    // Full frame capture
    pulseStart();
    chk("armed_state", 32'(oState), 32'd1);
    chk("armed_busy", 32'(oBusy), 32'd1);
    idle(G);
    for (int i = 0; i < N - 1; i++) begin
      px(pat(i), 1'b1, i);
      if (i == H) chk("row1_col0_addr", 32'(oWr_addr), 32'(H));
    end
    chk("capture_state", 32'(oState), 32'd2);
    px(pat(N - 1), 1'b1, N - 1);
    chk("done_state", 32'(oState), 32'd3);
    chk("done_ready", 32'(oFrame_ready), 32'd1);
    chk("done_count", 32'(oFrame_count), 32'd1);
    chk("done_busy", 32'(oBusy), 32'd0);
    idle(1);
    chk("frame1_writes", 32'(wrCount), 32'(N));

    // READY ignores pixels and iStart
    wrBase = wrCount;
    px(1'b1, 1'b0, 0);
    px(1'b1, 1'b0, 0);
    pulseStart();
    px(1'b1, 1'b0, 0);
    idle(1);
    chk("ready_hold_state", 32'(oState), 32'd3);
    chk("ready_no_writes", 32'(wrCount), 32'(wrBase));
    pulseDone();
    chk("read_done_state", 32'(oState), 32'd0);
    chk("read_done_ready", 32'(oFrame_ready), 32'd0);

    // Short gaps never arm a capture
    pulseStart();
    for (int k = 0; k < 6; k++) begin
      px(1'b1, 1'b0, 0);
      idle(5);
    end
    chk("short_gap_state", 32'(oState), 32'd1);
    chk("short_gap_no_writes", 32'(wrCount), 32'(wrBase));
    idle(G);
    for (int i = 0; i < 20; i++) px(pat(i + 3), 1'b1, i);
    pulseDone();
    chk("read_done_ignored", 32'(oState), 32'd2);

    // Premature gap aborts the capture
    idle(G - 1);
    chk("gap_not_yet", 32'(oState), 32'd2);
    idle(1);
    chk("short_pulse", 32'(oShort_frame), 32'd1);
    chk("short_state", 32'(oState), 32'd1);
    idle(1);
    chk("short_pulse_end", 32'(oShort_frame), 32'd0);

    // Restart at address 0; final pixel coinciding with a gap completes
    for (int i = 0; i < N - 1; i++) px(pat(i + 1), 1'b1, i);
    idle(G);
    px(1'b0, 1'b1, N - 1);
    chk("precedence_state", 32'(oState), 32'd3);
    chk("precedence_short", 32'(oShort_frame), 32'd0);
    chk("precedence_count", 32'(oFrame_count), 32'd2);
    pulseDone();

    // Asynchronous reset mid-capture
    pulseStart();
    idle(G);
    for (int i = 0; i < 10; i++) px(1'b1, 1'b1, i);
    #2;
    iRST = 1'b0;
    expQ.delete();
    #1;
    chk("arst_wr_en", 32'(oWr_en), 32'd0);
    chk("arst_wr_addr", 32'(oWr_addr), 32'd0);
    chk("arst_state", 32'(oState), 32'd0);
    chk("arst_busy", 32'(oBusy), 32'd0);
    chk("arst_count", 32'(oFrame_count), 32'd0);
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b1;
    wrBase = wrCount;
    idle(G);
    px(1'b1, 1'b0, 0);
    idle(1);
    chk("no_rearm_state", 32'(oState), 32'd0);
    chk("no_rearm_writes", 32'(wrCount), 32'(wrBase));

    // 256 frames wrap the frame counter
    for (int f = 1; f <= 256; f++) begin
      pulseStart();
      idle(G);
      for (int i = 0; i < N; i++) px(pat(i + f), 1'b1, i);
      if (f == 255) chk("count_255", 32'(oFrame_count), 32'd255);
      if (f == 256) chk("count_wrap", 32'(oFrame_count), 32'd0);
      pulseDone();
    end

    idle(2);
    chk("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
